// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, arbitrates the single memory port between
// redirects, stores and fetches, and buffers returned words toward decode.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Branch_Taken_i,
    input  logic [ADDR_WIDTH-1:0] Branch_Target_i,
    input  logic                  Jump_i,
    input  logic [ADDR_WIDTH-1:0] Jump_Target_i,
    input  logic                  Store_Req_i,
    input  logic [DATA_WIDTH-1:0] Store_Addr_i,
    input  logic [DATA_WIDTH-1:0] Store_Data_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic                  Write_Enable_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    output logic                  Store_Ack_o,
    output logic [DATA_WIDTH-1:0] Instruction_o,
    output logic [ADDR_WIDTH-1:0] PC_o,
    output logic                  Valid_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] pc;
    } ibuf_t;

    logic [ADDR_WIDTH-1:0] pc, inflight_pc, redirect_pc;
    logic                  inflight, valid, skid_vld;
    logic                  redirect, store_go, fetch_go;
    ibuf_t                 out_q, skid_q, ret_word;

    always_comb begin
        redirect    = Branch_Taken_i | Jump_i;
        redirect_pc = Branch_Taken_i ? Branch_Target_i : Jump_Target_i;
        // Reset gating keeps a held store request off the bus while in reset.
        store_go    = reset & ~redirect & Store_Req_i;
        fetch_go    = ~redirect & ~Store_Req_i & ~Stall_i & ~skid_vld;
        ret_word    = '{data: Instruction_i, pc: inflight_pc};
    end

    always_comb begin
        Address_o      = DATA_WIDTH'(pc);
        Write_Enable_o = 1'b0;
        Write_Data_o   = '0;
        Store_Ack_o    = 1'b0;
        if (store_go) begin
            Address_o      = Store_Addr_i;
            Write_Enable_o = 1'b1;
            Write_Data_o   = Store_Data_i;
            Store_Ack_o    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            skid_vld    <= 1'b0;
            skid_q      <= '0;
            out_q       <= '0;
            valid       <= 1'b0;
        end else if (redirect) begin
            // Word returning now belongs to the old path and is dropped.
            pc       <= redirect_pc;
            inflight <= 1'b0;
            skid_vld <= 1'b0;
            valid    <= 1'b0;
        end else begin
            inflight <= fetch_go;
            if (fetch_go) begin
                inflight_pc <= pc;
                pc          <= pc + ADDR_WIDTH'(1);
            end
            if (!Stall_i) begin
                if (skid_vld) begin
                    out_q    <= skid_q;
                    valid    <= 1'b1;
                    skid_vld <= 1'b0;
                end else if (inflight) begin
                    out_q <= ret_word;
                    valid <= 1'b1;
                end else begin
                    valid <= 1'b0;
                end
            end else if (inflight) begin
                // Issue is blocked while stalled, so one skid entry is enough.
                if (!valid) begin
                    out_q <= ret_word;
                    valid <= 1'b1;
                end else begin
                    skid_q   <= ret_word;
                    skid_vld <= 1'b1;
                end
            end
        end
    end

    assign Instruction_o = out_q.data;
    assign PC_o          = out_q.pc;
    assign Valid_o       = valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: 1-cycle-latency ROM model, directed
// scenarios and randomized traffic checked against an in-order stream model.
module tb_instruction_fetch_unit;
    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          Stall_i = 1'b0, Branch_Taken_i = 1'b0, Jump_i = 1'b0, Store_Req_i = 1'b0;
    logic [AW-1:0] Branch_Target_i = '0, Jump_Target_i = '0;
    logic [DW-1:0] Store_Addr_i = '0, Store_Data_i = '0;
    logic [DW-1:0] Instruction_i = '0, Address_o, Write_Data_o, Instruction_o;
    logic          Write_Enable_o, Store_Ack_o, Valid_o;
    logic [AW-1:0] PC_o;

    logic [DW-1:0] instr_i2 = '0, addr2, wd2, instr_o2;
    logic          we2, ack2, valid2;
    logic [AW-1:0] pc_o2;

    int total = 0;
    int bad   = 0;
    int n_deliv = 0;
    logic mon_en = 1'b0;

    instruction_fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(6'd0)) dut (
        .clk(clk), .reset(reset), .Stall_i(Stall_i),
        .Branch_Taken_i(Branch_Taken_i), .Branch_Target_i(Branch_Target_i),
        .Jump_i(Jump_i), .Jump_Target_i(Jump_Target_i),
        .Store_Req_i(Store_Req_i), .Store_Addr_i(Store_Addr_i), .Store_Data_i(Store_Data_i),
        .Instruction_i(Instruction_i), .Address_o(Address_o), .Write_Enable_o(Write_Enable_o),
        .Write_Data_o(Write_Data_o), .Store_Ack_o(Store_Ack_o), .Instruction_o(Instruction_o),
        .PC_o(PC_o), .Valid_o(Valid_o)
    );

    instruction_fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(6'd62)) dut62 (
        .clk(clk), .reset(reset), .Stall_i(Stall_i),
        .Branch_Taken_i(Branch_Taken_i), .Branch_Target_i(Branch_Target_i),
        .Jump_i(Jump_i), .Jump_Target_i(Jump_Target_i),
        .Store_Req_i(Store_Req_i), .Store_Addr_i(Store_Addr_i), .Store_Data_i(Store_Data_i),
        .Instruction_i(instr_i2), .Address_o(addr2), .Write_Enable_o(we2),
        .Write_Data_o(wd2), .Store_Ack_o(ack2), .Instruction_o(instr_o2),
        .PC_o(pc_o2), .Valid_o(valid2)
    );

    always #5 clk = ~clk;

    // ROM: word[i] = 0xA000_0000 + i, one cycle read latency
    always @(posedge clk) Instruction_i <= 32'hA000_0000 + Address_o;
    always @(posedge clk) instr_i2      <= 32'hA000_0000 + addr2;

    // Background stream model: decode must see consecutive words, restarted
    // at the target after every redirect, and a stalled output must hold.
    task automatic monitor_stream();
        logic [AW-1:0] exp_pc = '0;
        logic          prev_hold = 1'b0;
        logic [AW-1:0] prev_pc = '0;
        logic [DW-1:0] prev_instr = '0;
        forever begin
            @(negedge clk);
            if (!(mon_en && reset)) begin
                exp_pc    = '0;
                prev_hold = 1'b0;
            end else begin
                total++;
                if (Store_Req_i && !Branch_Taken_i && !Jump_i) begin
                    if (Store_Ack_o !== 1'b1 || Write_Enable_o !== 1'b1 ||
                        Address_o !== Store_Addr_i || Write_Data_o !== Store_Data_i) begin
                        bad++;
                        $display("FAIL store_port ack=%b we=%b addr=%h wd=%h want ack=1 we=1 addr=%h wd=%h",
                                 Store_Ack_o, Write_Enable_o, Address_o, Write_Data_o, Store_Addr_i, Store_Data_i);
                    end
                end else if (Store_Ack_o !== 1'b0 || Write_Enable_o !== 1'b0) begin
                    bad++;
                    $display("FAIL no_store ack=%b we=%b want 0/0", Store_Ack_o, Write_Enable_o);
                end
                if (prev_hold) begin
                    total++;
                    if (Valid_o !== 1'b1 || PC_o !== prev_pc || Instruction_o !== prev_instr) begin
                        bad++;
                        $display("FAIL stall_hold valid=%b pc=%0d instr=%h want 1/%0d/%h",
                                 Valid_o, PC_o, Instruction_o, prev_pc, prev_instr);
                    end
                end
                if (Valid_o === 1'b1 && !Stall_i) begin
                    total++;
                    if (PC_o !== exp_pc || Instruction_o !== 32'hA000_0000 + exp_pc) begin
                        bad++;
                        $display("FAIL stream_order pc=%0d instr=%h want %0d/%h",
                                 PC_o, Instruction_o, exp_pc, 32'hA000_0000 + exp_pc);
                    end
                    exp_pc = exp_pc + 1'b1;
                    n_deliv++;
                end
                if (Branch_Taken_i || Jump_i)
                    exp_pc = Branch_Taken_i ? Branch_Target_i : Jump_Target_i;
                prev_hold  = (Valid_o === 1'b1) && Stall_i && !Branch_Taken_i && !Jump_i;
                prev_pc    = PC_o;
                prev_instr = Instruction_o;
            end
        end
    endtask

    task automatic test_reset();
        logic [AW-1:0] e1, e2;
        Store_Req_i = 1'b1;
        Store_Addr_i = 32'h15;
        #12;
        total++;
        if (Valid_o !== 1'b0 || Instruction_o !== '0 || PC_o !== '0) begin
            bad++;
            $display("FAIL reset_regs valid=%b instr=%h pc=%0d want 0/0/0", Valid_o, Instruction_o, PC_o);
        end
        total++;
        if (Write_Enable_o !== 1'b0 || Store_Ack_o !== 1'b0 || Address_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_port we=%b ack=%b addr=%h want 0/0/0", Write_Enable_o, Store_Ack_o, Address_o);
        end
        total++;
        if (addr2 !== 32'd62 || valid2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_pc62 addr=%h valid=%b want 3e/0", addr2, valid2);
        end
        Store_Req_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        mon_en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            total++;
            if (c < 3) begin
                if (Valid_o !== 1'b0 || valid2 !== 1'b0) begin
                    bad++;
                    $display("FAIL startup_c%0d valid=%b valid62=%b want 0/0", c, Valid_o, valid2);
                end
            end else begin
                e1 = AW'(c - 3);
                e2 = AW'(62 + c - 3);
                if (Valid_o !== 1'b1 || PC_o !== e1 || Instruction_o !== 32'hA000_0000 + e1 ||
                    valid2 !== 1'b1 || pc_o2 !== e2 || instr_o2 !== 32'hA000_0000 + e2) begin
                    bad++;
                    $display("FAIL startup_c%0d v=%b pc=%0d i=%h v62=%b pc62=%0d i62=%h want pc %0d / %0d",
                             c, Valid_o, PC_o, Instruction_o, valid2, pc_o2, instr_o2, e1, e2);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit found = 0;
        int got = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (Valid_o === 1'b1 && PC_o === 6'd4) found = 1;
            else begin @(posedge clk); #1; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL stall_wait pc4 not seen within 40 cycles"); end
        Stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (Valid_o !== 1'b1 || PC_o !== 6'd4 || Instruction_o !== 32'hA000_0004) begin
                bad++;
                $display("FAIL stall_c%0d valid=%b pc=%0d instr=%h want 1/4/a0000004", i, Valid_o, PC_o, Instruction_o);
            end
        end
        Stall_i = 1'b0;
        for (int i = 0; i < 12 && got < 4; i++) begin
            if (Valid_o === 1'b1) begin
                total++;
                if (PC_o !== AW'(4 + got) || Instruction_o !== 32'hA000_0004 + got) begin
                    bad++;
                    $display("FAIL stall_release pc=%0d instr=%h want %0d", PC_o, Instruction_o, 4 + got);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (got != 4) begin bad++; $display("FAIL stall_release_count got=%0d want 4", got); end
    endtask

    task automatic test_branch();
        logic [AW-1:0] tgt;
        bit found;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                found = 0;
                for (int i = 0; i < 100 && !found; i++) begin
                    if (Address_o === 32'd9 && Write_Enable_o === 1'b0) found = 1;
                    else begin @(posedge clk); #1; end
                end
                total++;
                if (!found) begin bad++; $display("FAIL branch_wait pc9 not seen within 100 cycles"); end
                Branch_Taken_i = 1'b1; Branch_Target_i = 6'h20;
                Jump_i = 1'b0; Jump_Target_i = 6'h11;
                tgt = 6'h20;
            end else begin
                Branch_Taken_i = 1'b1; Branch_Target_i = 6'h30;
                Jump_i = 1'b1; Jump_Target_i = 6'h10;
                tgt = 6'h30;
            end
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk); #1;
                Branch_Taken_i = 1'b0;
                Jump_i = 1'b0;
                total++;
                if (c < 3 && Valid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL redirect%0d_bubble_c%0d valid=%b pc=%0d want valid 0", k, c, Valid_o, PC_o);
                end else if (c == 3 && (Valid_o !== 1'b1 || PC_o !== tgt || Instruction_o !== 32'hA000_0000 + tgt)) begin
                    bad++;
                    $display("FAIL redirect%0d_target valid=%b pc=%0d instr=%h want 1/%0d", k, Valid_o, PC_o, Instruction_o, tgt);
                end
            end
        end
    endtask

    task automatic test_store();
        int base;
        @(posedge clk); #1;
        Store_Req_i = 1'b1; Store_Addr_i = 32'd5; Store_Data_i = 32'hDEAD_BEEF;
        #1;
        total++;
        if (Write_Enable_o !== 1'b1 || Address_o !== 32'd5 || Write_Data_o !== 32'hDEAD_BEEF || Store_Ack_o !== 1'b1) begin
            bad++;
            $display("FAIL store_pulse we=%b addr=%h wd=%h ack=%b want 1/5/deadbeef/1",
                     Write_Enable_o, Address_o, Write_Data_o, Store_Ack_o);
        end
        @(posedge clk); #1;
        Store_Req_i = 1'b0;
        @(posedge clk); #1;
        Store_Req_i = 1'b1; Store_Addr_i = 32'h17; Store_Data_i = 32'h1234_5678;
        Branch_Taken_i = 1'b1; Branch_Target_i = 6'h08;
        #1;
        total++;
        if (Store_Ack_o !== 1'b0 || Write_Enable_o !== 1'b0) begin
            bad++;
            $display("FAIL store_vs_branch ack=%b we=%b want 0/0", Store_Ack_o, Write_Enable_o);
        end
        @(posedge clk); #1;
        Branch_Taken_i = 1'b0;
        #1;
        total++;
        if (Store_Ack_o !== 1'b1 || Write_Enable_o !== 1'b1 || Address_o !== 32'h17) begin
            bad++;
            $display("FAIL store_after_branch ack=%b we=%b addr=%h want 1/1/17", Store_Ack_o, Write_Enable_o, Address_o);
        end
        @(posedge clk); #1;
        Store_Req_i = 1'b0;
        base = n_deliv;
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (n_deliv - base < 4) begin
            bad++;
            $display("FAIL store_resume delivered=%0d want >=4", n_deliv - base);
        end
    endtask

    task automatic test_random();
        int base;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (Store_Ack_o) Store_Req_i = 1'b0;
            Stall_i         = ($urandom_range(99) < 30);
            Branch_Taken_i  = ($urandom_range(99) < 5);
            Jump_i          = ($urandom_range(99) < 5);
            Branch_Target_i = AW'($urandom);
            Jump_Target_i   = AW'($urandom);
            if (!Store_Req_i && $urandom_range(99) < 10) begin
                Store_Req_i  = 1'b1;
                Store_Addr_i = $urandom;
                Store_Data_i = $urandom;
            end
        end
        Stall_i = 1'b0; Branch_Taken_i = 1'b0; Jump_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (Store_Ack_o) Store_Req_i = 1'b0;
        end
        base = n_deliv;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (n_deliv - base < 5) begin
            bad++;
            $display("FAIL random_progress delivered=%0d want >=5", n_deliv - base);
        end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        @(posedge clk); #1;
        total++;
        if (Valid_o !== 1'b1) begin bad++; $display("FAIL areset_pre valid=%b want 1", Valid_o); end
        Store_Req_i = 1'b1; Store_Addr_i = 32'h9; Store_Data_i = 32'h5555_AAAA;
        #2;
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if (Valid_o !== 1'b0 || Instruction_o !== '0 || PC_o !== '0 ||
            Write_Enable_o !== 1'b0 || Store_Ack_o !== 1'b0 || Address_o !== 32'd0) begin
            bad++;
            $display("FAIL areset_now valid=%b instr=%h pc=%0d we=%b ack=%b addr=%h want all 0",
                     Valid_o, Instruction_o, PC_o, Write_Enable_o, Store_Ack_o, Address_o);
        end
        Store_Req_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 6 && !found; i++) begin
            @(posedge clk); #1;
            if (Valid_o === 1'b1) begin
                found = 1;
                total++;
                if (PC_o !== 6'd0 || Instruction_o !== 32'hA000_0000) begin
                    bad++;
                    $display("FAIL areset_restart pc=%0d instr=%h want 0/a0000000", PC_o, Instruction_o);
                end
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL areset_restart no valid output within 6 cycles"); end
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            monitor_stream();
        join_none
        test_reset();
        test_stall();
        test_branch();
        test_store();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream stage of the ROM/RAM memory system.
- Owns the program counter and drives the memory's shared address, write-enable and write-data inputs.
- Captures the returned word into an output instruction register with a valid/stall handshake toward decode.
- Arbitrates the single memory port between fetch, store requests and control-flow redirects, and absorbs the memory's 1-cycle read latency.

Parameters:
DATA_WIDTH, 32, width of instruction/data words and of the memory address bus
ADDR_WIDTH, 6, PC width in words; PC wraps at 2^ADDR_WIDTH
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Stall_i  input  1  decode not ready; output register must hold
Branch_Taken_i  input  1  redirect PC to Branch_Target_i
Branch_Target_i  input  ADDR_WIDTH  branch word address
Jump_i  input  1  redirect PC to Jump_Target_i
Jump_Target_i  input  ADDR_WIDTH  jump word address
Store_Req_i  input  1  store request; held until Store_Ack_o
Store_Addr_i  input  DATA_WIDTH  store word address
Store_Data_i  input  DATA_WIDTH  store data
Instruction_i  input  DATA_WIDTH  memory read data, valid 1 cycle after address issue
Address_o  output  DATA_WIDTH  memory address (combinational)
Write_Enable_o  output  1  memory write enable (combinational)
Write_Data_o  output  DATA_WIDTH  memory write data (combinational)
Store_Ack_o  output  1  store granted this cycle (combinational pulse)
Instruction_o  output  DATA_WIDTH  instruction register
PC_o  output  ADDR_WIDTH  word address of Instruction_o
Valid_o  output  1  Instruction_o holds a live instruction

Behaviour:
- Reset (async, reset=0):
  - PC=RESET_PC.
  - Instruction_o=0, PC_o=0, Valid_o=0.
  - Inflight and skid flags cleared.
  - Store_Ack_o=0, Write_Enable_o=0.
  - Address_o = zero-extended PC.
- Per-cycle port priority: redirect > store > fetch > idle.
- Redirect (Branch_Taken_i or Jump_i; Branch_Taken_i wins if both):
  - PC <= target.
  - Inflight word squashed (its return next cycle is dropped); skid cleared; Valid_o <= 0.
  - No issue and no store ack this cycle.
  - Honoured even while stalled.
- Store (no redirect):
  - Address_o=Store_Addr_i, Write_Data_o=Store_Data_i, Write_Enable_o=1, Store_Ack_o=1.
  - No fetch issued; PC unchanged.
  - The word returned next cycle is not a fetch and is ignored.
  - Allowed while stalled.
- Fetch issue:
  - Condition: no redirect, no store, Stall_i=0, skid empty.
  - Address_o = zero-extended PC; inflight <= 1; inflight_pc <= PC; PC <= PC+1 (mod 2^ADDR_WIDTH).
- Idle: Address_o=PC, Write_Enable_o=0, inflight <= 0.
- Return (inflight=1, not squashed):
  - Output register loads {Instruction_i, inflight_pc} when Stall_i=0 or Valid_o=0, and sets Valid_o.
  - Otherwise the word goes to a 1-entry skid {data, pc}.
- Consumption:
  - Stall_i=0 and skid full: output loads from skid, skid empties.
  - Stall_i=0, no new word: Valid_o <= 0.
- Latency: issue in cycle N; word on Instruction_i in N+1; visible on Instruction_o/Valid_o in N+2.
- Throughput: 1 instruction/cycle, unstalled.
- Stall safety:
  - At most one inflight word during a stall, since issue is blocked while stalled; the skid always suffices.
  - No instruction is lost or duplicated across any stall pattern.
- PC wrap: 2^ADDR_WIDTH-1 → 0, no flag.
- Reset mid-operation: all state cleared immediately; fetch restarts from RESET_PC on the first cycle with reset=1.

Test Plan:
- Memory model with 1-cycle read latency, word[i]=0xA000_0000+i.
- Reset release, Stall_i=0 → Valid_o=1 from the 3rd cycle; Instruction_o/PC_o = 0xA0000000/0, 0xA0000001/1, ... one per cycle.
- Stall_i=1 for 3 cycles after PC_o=4 → Instruction_o holds 0xA0000004; after release the next outputs are 5, 6, 7 with none skipped or repeated.
- Branch_Taken_i=1, target 0x20, while PC=9 → Valid_o=0 for 2 cycles, next PC_o=0x20 with 0xA0000020; words 9/10 never appear. Repeat with Jump_i plus Branch_Taken_i together → branch target used.
- Store_Req_i, addr 5, data 0xDEADBEEF, mid-stream → one cycle with Write_Enable_o=1, Address_o=5, Write_Data_o=0xDEADBEEF, Store_Ack_o=1; stream resumes in order with a 1-cycle bubble. Store plus branch in the same cycle → no ack, redirect taken, ack on the following cycle.
- RESET_PC=62, run 4 fetches → PC_o sequence 62, 63, 0, 1.
- Assert reset mid-stream between clock edges → Valid_o, Instruction_o and Write_Enable_o go to 0 without a clock edge; restart begins at RESET_PC.
